// File: rtl/hqc_frame_loader.sv
// -----------------------------------------------------------------------------
// hqc_frame_loader
//
// Accepts a framed byte stream from a uart_rx:
//   SYNC_BYTE, CT_BYTES ciphertext bytes, SK_BYTES secret-key bytes, XOR checksum
// Ciphertext bytes go to a byte-wide memory. Secret-key bytes are packed into
// SK_WORD_BYTES-wide words (lane order set by BIG_ENDIAN) and then stored.
// The result is reported to the host as one ACK/NAK byte over a ready/valid
// handshake. The decapsulation core reads both memories through registered,
// state-independent read ports.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   rx_valid, rx_data    one received byte per strobe
//   start, abort         arm the loader / cancel a load in progress (pulses)
//   busy, done, success  progress and result levels; err_code 0 ok, 1 checksum,
//                        2 timeout, 3 abort
//   tx_valid, tx_data,   status byte (8'h06 ACK, 8'h15 NAK) towards uart_tx
//   tx_ready
//   ct_addr/ct_ce/ct_data  CT read port, 1-cycle latency, holds when ce low
//   sk_addr/sk_ce/sk_data  SK read port, 1-cycle latency, holds when ce low
// -----------------------------------------------------------------------------
module hqc_frame_loader #(
   parameter int          CT_BYTES       = 4481,
   parameter int          SK_BYTES       = 2296,
   parameter int          SK_WORD_BYTES  = 8,
   parameter bit          BIG_ENDIAN     = 1'b0,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
   localparam int SK_WORDS = (SK_BYTES + SK_WORD_BYTES - 1) / SK_WORD_BYTES,
   localparam int CT_AW    = (CT_BYTES > 1) ? $clog2(CT_BYTES) : 1,
   localparam int SK_AW    = (SK_WORDS > 1) ? $clog2(SK_WORDS) : 1,
   localparam int SKW      = 8 * SK_WORD_BYTES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             success,
   output logic [1:0]       err_code,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   input  logic             tx_ready,
   input  logic [CT_AW-1:0] ct_addr,
   input  logic             ct_ce,
   output logic [7:0]       ct_data,
   input  logic [SK_AW-1:0] sk_addr,
   input  logic             sk_ce,
   output logic [SKW-1:0]   sk_data
);

   localparam int   SKB_W = (SK_BYTES > 1) ? $clog2(SK_BYTES) : 1;
   localparam int   LW    = (SK_WORD_BYTES > 1) ? $clog2(SK_WORD_BYTES) : 1;
   localparam bit   TO_EN = (TIMEOUT_CYCLES != 0);

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_ABORT   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_LOAD_CT, S_LOAD_SK, S_CSUM, S_REPORT, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CT_AW-1:0]  ct_cnt_q, ct_cnt_d;
   logic [SKB_W-1:0]  sk_cnt_q, sk_cnt_d;
   logic [SK_AW-1:0]  word_q, word_d;
   logic [LW-1:0]     lane_q, lane_d;
   logic [SKW-1:0]    wbuf_q, wbuf_d;
   logic [7:0]        csum_q, csum_d;
   logic [31:0]       idle_q, idle_d;
   logic [1:0]        err_q, err_d;
   logic              done_q, done_d;
   logic              success_q, success_d;
   logic [7:0]        ct_data_q, ct_data_d;
   logic [SKW-1:0]    sk_data_q, sk_data_d;

   logic              ct_we, sk_we;
   logic              ct_last, sk_last, lane_last;
   logic [LW-1:0]     lane_pos;
   logic [SKW-1:0]    sk_wdata;

   logic [7:0]        ct_mem [CT_BYTES];
   logic [SKW-1:0]    sk_mem [SK_WORDS];

   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done     = done_q;
   assign success  = success_q;
   assign err_code = err_q;
   assign tx_valid = (state_q == S_REPORT);
   assign tx_data  = tx_valid ? ((err_q == ERR_OK) ? 8'h06 : 8'h15) : 8'h00;
   assign ct_data  = ct_data_q;
   assign sk_data  = sk_data_q;

   assign ct_last   = (ct_cnt_q == CT_AW'(CT_BYTES - 1));
   assign sk_last   = (sk_cnt_q == SKB_W'(SK_BYTES - 1));
   assign lane_last = (lane_q == LW'(SK_WORD_BYTES - 1));

   // Physical byte position of the current lane; big-endian fills from the top.
   assign lane_pos = BIG_ENDIAN ? (LW'(SK_WORD_BYTES - 1) - lane_q) : lane_q;
   // The buffer is zero after every commit, so OR-ing the incoming byte in
   // leaves unfilled lanes of a short final word at 0.
   assign sk_wdata = wbuf_q | (SKW'(rx_data) << {lane_pos, 3'b000});

   always_comb begin
      state_d   = state_q;
      ct_cnt_d  = ct_cnt_q;
      sk_cnt_d  = sk_cnt_q;
      word_d    = word_q;
      lane_d    = lane_q;
      wbuf_d    = wbuf_q;
      csum_d    = csum_q;
      idle_d    = idle_q;
      err_d     = err_q;
      done_d    = done_q;
      success_d = success_q;
      ct_we     = 1'b0;
      sk_we     = 1'b0;

      // abort wins over a byte or a timeout arriving in the same cycle
      if (busy && abort) begin
         state_d   = S_DONE;
         err_d     = ERR_ABORT;
         done_d    = 1'b1;
         success_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d   = S_SYNC;
                  ct_cnt_d  = '0;
                  sk_cnt_d  = '0;
                  word_d    = '0;
                  lane_d    = '0;
                  wbuf_d    = '0;
                  csum_d    = '0;
                  idle_d    = '0;
                  err_d     = ERR_OK;
                  done_d    = 1'b0;
                  success_d = 1'b0;
               end
            end
            S_SYNC: begin
               if (rx_valid && (rx_data == SYNC_BYTE)) begin
                  state_d = S_LOAD_CT;
                  idle_d  = '0;
               end
            end
            S_LOAD_CT, S_LOAD_SK, S_CSUM: begin
               if (rx_valid) begin
                  idle_d = '0;
                  csum_d = csum_q ^ rx_data;
                  if (state_q == S_LOAD_CT) begin
                     ct_we    = 1'b1;
                     ct_cnt_d = ct_cnt_q + CT_AW'(1);
                     if (ct_last) state_d = S_LOAD_SK;
                  end else if (state_q == S_LOAD_SK) begin
                     sk_cnt_d = sk_cnt_q + SKB_W'(1);
                     if (lane_last || sk_last) begin
                        sk_we  = 1'b1;
                        wbuf_d = '0;
                        lane_d = '0;
                        word_d = word_q + SK_AW'(1);
                     end else begin
                        wbuf_d = sk_wdata;
                        lane_d = lane_q + LW'(1);
                     end
                     if (sk_last) state_d = S_CSUM;
                  end else begin
                     err_d   = (rx_data == csum_q) ? ERR_OK : ERR_CSUM;
                     state_d = S_REPORT;
                  end
               end else if (TO_EN) begin
                  // idle_q counts completed silent cycles; this one is the Nth
                  if (idle_q == TIMEOUT_CYCLES - 1) begin
                     err_d   = ERR_TIMEOUT;
                     state_d = S_REPORT;
                  end else begin
                     idle_d = idle_q + 32'd1;
                  end
               end
            end
            S_REPORT: begin
               if (tx_ready) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  success_d = (err_q == ERR_OK);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Read ports: registered, hold when not enabled, independent of load state.
   always_comb begin
      ct_data_d = ct_data_q;
      sk_data_d = sk_data_q;
      if (ct_ce) ct_data_d = ct_mem[ct_addr];
      if (sk_ce) sk_data_d = sk_mem[sk_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ct_cnt_q  <= '0;
         sk_cnt_q  <= '0;
         word_q    <= '0;
         lane_q    <= '0;
         wbuf_q    <= '0;
         csum_q    <= '0;
         idle_q    <= '0;
         err_q     <= ERR_OK;
         done_q    <= 1'b0;
         success_q <= 1'b0;
         ct_data_q <= '0;
         sk_data_q <= '0;
      end else begin
         state_q   <= state_d;
         ct_cnt_q  <= ct_cnt_d;
         sk_cnt_q  <= sk_cnt_d;
         word_q    <= word_d;
         lane_q    <= lane_d;
         wbuf_q    <= wbuf_d;
         csum_q    <= csum_d;
         idle_q    <= idle_d;
         err_q     <= err_d;
         done_q    <= done_d;
         success_q <= success_d;
         ct_data_q <= ct_data_d;
         sk_data_q <= sk_data_d;
      end
   end

   // Storage keeps its contents across reset and aborted loads.
   always_ff @(posedge clk) begin
      if (ct_we) ct_mem[ct_cnt_q] <= rx_data;
      if (sk_we) sk_mem[word_q]   <= sk_wdata;
   end

endmodule

// File: tb/tb_hqc_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_hqc_frame_loader
// Drives one little-endian and one big-endian loader with identical frames.
// Expected status comes from the frame script and spec timing; expected memory
// contents come from byte arrays of what was sent, packed by plain arithmetic.
// -----------------------------------------------------------------------------
module tb_hqc_frame_loader;

   localparam int CTB = 4, SKB = 12, W = 8, TO = 100;
   localparam int N   = CTB + SKB;
   localparam int NW  = (SKB + W - 1) / W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx_valid = 1'b0, start = 1'b0, abort = 1'b0, tx_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [1:0] ct_addr = '0;
   logic       sk_addr = 1'b0;
   logic       ct_ce = 1'b0, sk_ce = 1'b0;

   logic [1:0]       busy_o, done_o, success_o, txv_o;
   logic [1:0][1:0]  err_o;
   logic [1:0][7:0]  txd_o, ctd_o;
   logic [1:0][63:0] skd_o;

   int checks = 0, failures = 0;

   bit         chk_en = 1'b0;
   bit         exp_busy = 1'b0, exp_done = 1'b0, exp_success = 1'b0, exp_txv = 1'b0;
   logic [1:0] exp_err = 2'd0;
   logic [7:0] exp_txd = 8'h00;

   logic [7:0]  fct [CTB];
   logic [7:0]  fsk [SKB];
   logic [7:0]  ref_ct [CTB];
   logic [7:0]  skb [SKB];
   logic [63:0] ref_le [NW];
   logic [63:0] ref_be [NW];

   always #5 clk = ~clk;

   for (genvar d = 0; d < 2; d++) begin : g_dut
      hqc_frame_loader #(
         .CT_BYTES(CTB), .SK_BYTES(SKB), .SK_WORD_BYTES(W), .BIG_ENDIAN(d == 1),
         .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
      ) u_dut (
         .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
         .start(start), .abort(abort), .busy(busy_o[d]), .done(done_o[d]),
         .success(success_o[d]), .err_code(err_o[d]), .tx_valid(txv_o[d]),
         .tx_data(txd_o[d]), .tx_ready(tx_ready), .ct_addr(ct_addr), .ct_ce(ct_ce),
         .ct_data(ctd_o[d]), .sk_addr(sk_addr), .sk_ce(sk_ce), .sk_data(skd_o[d])
      );
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
      end
   endtask

   // Status outputs against the expected values, every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy[%0d]", d), 64'(busy_o[d]), 64'(exp_busy));
            chk($sformatf("done[%0d]", d), 64'(done_o[d]), 64'(exp_done));
            chk($sformatf("err[%0d]", d), 64'(err_o[d]), 64'(exp_err));
            chk($sformatf("tx_valid[%0d]", d), 64'(txv_o[d]), 64'(exp_txv));
            if (exp_done) chk($sformatf("success[%0d]", d), 64'(success_o[d]), 64'(exp_success));
            if (exp_txv)  chk($sformatf("tx_data[%0d]", d), 64'(txd_o[d]), 64'(exp_txd));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit allow_start);
      for (int i = 0; i < n; i++) begin
         if (allow_start && $urandom_range(0, 7) == 0) start = 1'b1;
         tick();
         start = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom_range(0, 255));
   endtask

   // Bytes offered while the loader is not listening.
   task automatic noise(input int n);
      for (int i = 0; i < n; i++) begin
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom_range(0, 255));
         tick();
      end
      rx_valid = 1'b0;
   endtask

   task automatic do_abort(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      abort    = 1'b1;
      tick();
      abort    = 1'b0;
      rx_valid = 1'b0;
      exp_busy = 0; exp_done = 1; exp_err = 2'd3; exp_success = 0; exp_txv = 0;
   endtask

   // SK word j/W as it must look once byte j completes it.
   task automatic commit(input int j);
      int wi;
      wi = j / W;
      ref_le[wi] = '0;
      ref_be[wi] = '0;
      for (int k = 0; k < W; k++) begin
         if (wi * W + k <= j) begin
            ref_le[wi][8*k +: 8]       = skb[wi * W + k];
            ref_be[wi][8*(W-1-k) +: 8] = skb[wi * W + k];
         end
      end
   endtask

   // abort_at: -2 in SYNC, 0..N with frame byte k, N+1 in REPORT, -1 never.
   // to_at: go silent after frame byte to_at (-1 never).
   task automatic run_frame(input int junk, input int max_gap, input int abort_at,
                            input int to_at, input logic [7:0] cx, input int bp);
      logic [7:0] b, cs;
      int g;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_busy = 1; exp_done = 0; exp_err = 2'd0; exp_txv = 0;
      for (int j = 0; j < junk; j++) begin
         idle($urandom_range(0, 2), 1'b1);
         b = (j == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h5A;
         send(b);
      end
      if (junk > 1) idle(TO + 20, 1'b0);
      if (abort_at == -2) begin
         do_abort(8'hA5);
         return;
      end
      send(8'hA5);
      cs = 8'h00;
      for (int k = 0; k <= N; k++) begin
         g = (max_gap == TO - 1 && k == CTB) ? TO - 1 : $urandom_range(0, max_gap);
         idle(g, 1'b1);
         b = (k < CTB) ? fct[k] : (k < N) ? fsk[k - CTB] : (cs ^ cx);
         if (k == abort_at) begin
            do_abort(b);
            return;
         end
         send(b);
         if (k < CTB) ref_ct[k] = b;
         else if (k < N) begin
            skb[k - CTB] = b;
            if (((k - CTB) % W) == W - 1 || k == N - 1) commit(k - CTB);
         end
         cs ^= b;
         if (k == N) begin
            exp_txv = 1;
            exp_err = (cx == 8'h00) ? 2'd0 : 2'd1;
            exp_txd = (cx == 8'h00) ? 8'h06 : 8'h15;
         end else if (k == to_at) begin
            idle(TO, 1'b0);
            exp_txv = 1; exp_err = 2'd2; exp_txd = 8'h15;
            break;
         end
      end
      for (int i = 0; i < bp; i++) begin
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom_range(0, 255));
         tick();
      end
      rx_valid = 1'b0;
      if (abort_at == N + 1) begin
         do_abort(8'h00);
         return;
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      exp_txv = 0; exp_busy = 0; exp_done = 1; exp_success = (exp_err == 2'd0);
   endtask

   task automatic rd_ct(input int a, input logic [7:0] e);
      ct_ce   = 1'b1;
      ct_addr = 2'(a);
      tick();
      ct_ce   = 1'b0;
      ct_addr = 2'(a + 1);
      chk($sformatf("ct_rd_le[%0d]", a), 64'(ctd_o[0]), 64'(e));
      chk($sformatf("ct_rd_be[%0d]", a), 64'(ctd_o[1]), 64'(e));
      tick();
      chk($sformatf("ct_hold[%0d]", a), 64'(ctd_o[0]), 64'(e));
   endtask

   task automatic rd_sk(input int a, input logic [63:0] ele, input logic [63:0] ebe);
      sk_ce   = 1'b1;
      sk_addr = 1'(a);
      tick();
      sk_ce   = 1'b0;
      sk_addr = 1'(a + 1);
      chk($sformatf("sk_rd_le[%0d]", a), skd_o[0], ele);
      chk($sformatf("sk_rd_be[%0d]", a), skd_o[1], ebe);
      tick();
      chk($sformatf("sk_hold_be[%0d]", a), skd_o[1], ebe);
   endtask

   task automatic read_all();
      for (int a = 0; a < CTB; a++) rd_ct(a, ref_ct[a]);
      for (int w = 0; w < NW; w++) rd_sk(w, ref_le[w], ref_be[w]);
   endtask

   task automatic fixed_data(input logic [7:0] cbase, input logic [7:0] sbase);
      for (int i = 0; i < CTB; i++) fct[i] = cbase + 8'(i);
      for (int i = 0; i < SKB; i++) fsk[i] = sbase + 8'(i);
   endtask

   initial begin
      #900_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int ab, to;
      logic [7:0] cx;
      // reset values
      tick(); tick();
      chk_en = 1'b1;
      tick();
      for (int d = 0; d < 2; d++) begin
         chk("rst_success", 64'(success_o[d]), 64'd0);
         chk("rst_tx_data", 64'(txd_o[d]), 64'd0);
         chk("rst_ct_data", 64'(ctd_o[d]), 64'd0);
         chk("rst_sk_data", skd_o[d], 64'd0);
      end
      rst = 1'b0;
      noise(6);

      // clean frame with a leading junk byte
      fixed_data(8'h01, 8'h10);
      run_frame(1, 0, -1, -1, 8'h00, 0);
      noise(3);
      chk("model_sk0_le", ref_le[0], 64'h1716151413121110);
      chk("model_sk1_be", ref_be[1], 64'h18191A1B00000000);
      for (int a = 0; a < CTB; a++) rd_ct(a, 8'(a + 1));
      rd_sk(0, 64'h1716151413121110, 64'h1011121314151617);
      rd_sk(1, 64'h000000001B1A1918, 64'h18191A1B00000000);

      // checksum mismatch (final byte 05) with 50 cycles of back-pressure
      run_frame(1, 0, -1, -1, 8'h01, 50);
      chk("mismatch_err", 64'(err_o[0]), 64'd1);
      chk("mismatch_success", 64'(success_o[1]), 64'd0);

      // silent after the 3rd CT byte
      run_frame(1, 0, -1, 2, 8'h00, 3);
      chk("timeout_err", 64'(err_o[1]), 64'd2);
      read_all();

      // abort together with an SK byte in the second word
      fixed_data(8'h20, 8'h40);
      run_frame(0, 1, CTB + 10, -1, 8'h00, 0);
      chk("abort_err", 64'(err_o[0]), 64'd3);
      read_all();
      rd_sk(1, 64'h000000001B1A1918, 64'h18191A1B00000000);

      // randomized frames
      for (int it = 0; it < 14; it++) begin
         for (int i = 0; i < CTB; i++) fct[i] = 8'($urandom_range(0, 255));
         for (int i = 0; i < SKB; i++) fsk[i] = 8'($urandom_range(0, 255));
         ab = -1;
         to = -1;
         case ($urandom_range(0, 5))
            0: ab = int'($urandom_range(0, N + 3)) - 2;
            1: to = int'($urandom_range(0, N - 1));
            default: ;
         endcase
         cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         run_frame($urandom_range(0, 3), (it == 3) ? TO - 1 : $urandom_range(0, 3),
                   ab, to, cx, $urandom_range(0, 6));
         noise(3);
         read_all();
      end

      // reset in the middle of the CT section
      fixed_data(8'h31, 8'h50);
      rd_ct(1, ref_ct[1]);
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_busy = 1; exp_done = 0; exp_err = 2'd0; exp_txv = 0;
      send(8'hA5);
      send(fct[0]); ref_ct[0] = fct[0];
      send(fct[1]); ref_ct[1] = fct[1];
      #2;
      rst = 1'b1;
      exp_busy = 0; exp_done = 0; exp_err = 2'd0; exp_txv = 0; exp_success = 0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("midrst_busy", 64'(busy_o[d]), 64'd0);
         chk("midrst_ct_data", 64'(ctd_o[d]), 64'd0);
         chk("midrst_sk_data", skd_o[d], 64'd0);
         chk("midrst_tx_valid", 64'(txv_o[d]), 64'd0);
      end
      tick();
      rst = 1'b0;
      noise(2);

      // full frame after the reset
      fixed_data(8'h01, 8'h10);
      run_frame(0, 2, -1, -1, 8'h00, 2);
      chk("second_pass_success", 64'(success_o[0]), 64'd1);
      read_all();

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
